// File: rtl/scan_chain_ctrl.sv
// Scan-chain load/unload/capture driver: shifts a parallel pattern into a scan chain while
// unloading the previous contents, then issues one capture cycle. SCAN_MISR_EN adds a MISR on so.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 32,
  parameter int CNT_W     = 6,
  parameter int SIG_W     = 16
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic                 so,
  output logic                 ssel,
  output logic                 sdi,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] resp,
  output logic [SIG_W-1:0]     signature
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [CHAIN_LEN-1:0] r_pat;
  logic [CHAIN_LEN-1:0] r_unload;
  logic [CHAIN_LEN-1:0] r_resp;
  logic                 r_ssel;
  logic                 r_sdi;
  logic                 r_busy;
  logic                 r_done;

  assign ssel = r_ssel;
  assign sdi  = r_sdi;
  assign busy = r_busy;
  assign done = r_done;
  assign resp = r_resp;

  // Operation sequencer; r_pat is pre-shifted so its MSB is always the next bit to drive.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state  <= ST_IDLE;
      r_cnt    <= {CNT_W{1'b0}};
      r_pat    <= {CHAIN_LEN{1'b0}};
      r_unload <= {CHAIN_LEN{1'b0}};
      r_resp   <= {CHAIN_LEN{1'b0}};
      r_ssel   <= 1'b0;
      r_sdi    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_pat   <= {pattern[CHAIN_LEN-2:0], 1'b0};
            r_sdi   <= pattern[CHAIN_LEN-1];
            r_ssel  <= 1'b1;
            r_busy  <= 1'b1;
            r_cnt   <= {CNT_W{1'b0}};
            r_state <= ST_SHIFT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          r_unload <= {r_unload[CHAIN_LEN-2:0], so};
          if (r_cnt == LAST_CNT) begin
            r_ssel  <= 1'b0;
            r_sdi   <= 1'b0;
            r_state <= ST_CAPTURE;
          end else begin
            r_sdi <= r_pat[CHAIN_LEN-1];
            r_pat <= {r_pat[CHAIN_LEN-2:0], 1'b0};
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_CAPTURE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_resp  <= r_unload;
          r_cnt   <= {CNT_W{1'b0}};
          r_state <= ST_IDLE;
        end
        default: begin
          r_ssel  <= 1'b0;
          r_sdi   <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_cnt   <= {CNT_W{1'b0}};
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SCAN_MISR_EN
  localparam logic [SIG_W-1:0] MISR_POLY = SIG_W'(16'h1021);

  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] sig, input logic din);
    misr_next = {sig[SIG_W-2:0], 1'b0}
              ^ (sig[SIG_W-1] ? MISR_POLY : {SIG_W{1'b0}})
              ^ {{(SIG_W-1){1'b0}}, din};
  endfunction

  logic [SIG_W-1:0] r_sig;
  assign signature = r_sig;

  // Signature accumulates every unloaded bit across operations; only reset clears it.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_sig <= {SIG_W{1'b0}};
    end else if (r_state == ST_SHIFT) begin
      r_sig <= misr_next(r_sig, so);
    end else begin
      r_sig <= r_sig;
    end
  end
`else
  assign signature = {SIG_W{1'b0}};
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Scoreboard bench for scan_chain_ctrl on an 8-flop chain whose functional input is its own QN.
// An operation-level model predicts resp/signature per accepted start; a monitor checks at negedge.
module tb_scan_chain_ctrl;
  localparam int N     = 8;
  localparam int CNT_W = 4;
  localparam int SIG_W = 16;
  localparam logic [N-1:0] CHAIN_INIT = 8'h96;
`ifdef SCAN_MISR_EN
  localparam bit MISR_ON = 1'b1;
`else
  localparam bit MISR_ON = 1'b0;
`endif

  typedef struct packed {
    logic [N-1:0]     resp;
    logic [SIG_W-1:0] sig;
  } exp_t;

  logic             CLK     = 1'b0;
  logic             RSTN    = 1'b0;
  logic             start   = 1'b0;
  logic [N-1:0]     pattern = 8'h00;
  logic             so;
  logic             ssel, sdi, busy, done;
  logic [N-1:0]     resp;
  logic [SIG_W-1:0] signature;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  scan_chain_ctrl #(.CHAIN_LEN(N), .CNT_W(CNT_W), .SIG_W(SIG_W)) dut (
    .CLK(CLK), .RSTN(RSTN), .start(start), .pattern(pattern), .so(so),
    .ssel(ssel), .sdi(sdi), .busy(busy), .done(done), .resp(resp), .signature(signature)
  );

  // Chain of sdffs1 flops, DIN = QN; clocked only during operations so idle cycles do not toggle it.
  logic [N-1:0] chain = CHAIN_INIT;
  assign so = chain[N-1];
  always @(posedge CLK) begin
    if (busy === 1'b1) chain <= (ssel === 1'b1) ? {chain[N-2:0], sdi} : ~chain;
  end

  function automatic logic [SIG_W-1:0] misr_feed(input logic [SIG_W-1:0] sig, input logic [N-1:0] bits);
    logic [SIG_W-1:0] s;
    s = sig;
    for (int i = N - 1; i >= 0; i--)
      s = {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? 16'h1021 : 16'h0000) ^ {15'd0, bits[i]};
    return s;
  endfunction

  // Chain contents after k serial shifts of pat (MSB first) into old.
  function automatic logic [N-1:0] partial_chain(input logic [N-1:0] old, input logic [N-1:0] pat, input int k);
    logic [2*N-1:0] w;
    w = {old, pat} << k;
    return w[2*N-1:N];
  endfunction

  // Reference model: an operation lasts N+2 cycles from acceptance; m_left counts edges until done.
  exp_t             exp_q[$];
  int               m_left  = 0;
  logic             m_done  = 1'b0;
  logic [N-1:0]     m_chain = CHAIN_INIT;
  logic [N-1:0]     m_old   = 8'h00;
  logic [N-1:0]     m_pat   = 8'h00;
  logic [N-1:0]     m_resp  = 8'h00;
  logic [SIG_W-1:0] m_sig   = 16'h0000;
  logic [SIG_W-1:0] next_sig;
  assign next_sig = MISR_ON ? misr_feed(m_sig, m_chain) : 16'h0000;

  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      if (m_left > 0) begin
        m_chain <= partial_chain(m_old, m_pat, N + 1 - m_left);
        void'(exp_q.pop_back());
      end
      m_left <= 0;
      m_done <= 1'b0;
      m_resp <= 8'h00;
      m_sig  <= 16'h0000;
    end else begin
      m_done <= (m_left == 1);
      if (m_left == 1) m_resp <= m_old;
      if (m_left > 0) begin
        m_left <= m_left - 1;
      end else if (start) begin
        m_left  <= N + 1;
        m_old   <= m_chain;
        m_pat   <= pattern;
        m_chain <= ~pattern;
        m_sig   <= next_sig;
        exp_q.push_back({m_chain, next_sig});
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
  endtask

  // Monitor: cycle-level outputs against the model, resp/signature against the scoreboard at done.
  always @(negedge CLK) begin
    exp_t e;
    chk("ssel", {63'd0, ssel}, {63'd0, m_left >= 2});
    chk("busy", {63'd0, busy}, {63'd0, m_left >= 1});
    chk("sdi", {63'd0, sdi}, {63'd0, (m_left >= 2) ? m_pat[m_left-2] : 1'b0});
    chk("done", {63'd0, done}, {63'd0, m_done});
    chk("resp_hold", {56'd0, resp}, {56'd0, m_resp});
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp", {56'd0, resp}, {56'd0, e.resp});
        chk("signature", {48'd0, signature}, {48'd0, e.sig});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      pattern = 8'($urandom);
    end
  endtask

  task automatic issue(input logic [N-1:0] p);
    @(negedge CLK);
    start   = 1'b1;
    pattern = p;
    @(negedge CLK);
    start   = 1'b0;
    pattern = 8'($urandom);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    #1;
    chk("reset_resp", {56'd0, resp}, 64'd0);
    chk("reset_signature", {48'd0, signature}, 64'd0);
    #1 RSTN = 1'b1;

    issue(8'hA5); idle(N + 2);
    issue(8'h3C); idle(N + 3);

    // start held high: exactly one operation per done, re-accepted in the done cycle
    @(negedge CLK);
    start = 1'b1;
    idle(3 * (N + 2));
    start = 1'b0;
    idle(N + 3);

    // reset after four shift edges
    issue(8'h5C);
    repeat (4) @(posedge CLK);
    #2 RSTN = 1'b0;
    #1;
    chk("arst_ssel", {63'd0, ssel}, 64'd0);
    chk("arst_sdi", {63'd0, sdi}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_resp", {56'd0, resp}, 64'd0);
    chk("arst_signature", {48'd0, signature}, 64'd0);
    @(negedge CLK);
    #2 RSTN = 1'b1;
    issue(8'($urandom)); idle(N + 2);

    issue(8'hFF); idle(N + 2);
    issue(8'h00); idle(N + 3);

    // random patterns and gaps, some of which land while busy
    for (int i = 0; i < 10; i++) begin
      issue(8'($urandom));
      idle(int'($urandom_range(0, N + 4)));
    end
    idle(N + 4);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
